// File: rtl/stream_upsizer_arbiter_pkg.sv
// Shared stream helpers: arbiter state encoding and a width helper that never
// returns zero, used for id and beat-counter widths.
package stream_upsizer_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // $clog2 with a floor of 1 so single-value ranges still get a real bit.
  function automatic int clog2_min1(input int v);
    return (v > 2) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/stream_upsizer_arbiter_if.sv
// Bundle of the N narrow request streams, the single upsizer-facing stream and
// the arbiter's debug state. The slave modport is the arbiter's view.
interface stream_upsizer_arbiter_if
  import stream_upsizer_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int IW = clog2_min1(N)
);
  // Valid/ready: a beat moves on a rising clk edge where valid and ready are
  // both high; valid never depends on ready, ready may depend on valid.
  logic [N*DW-1:0] s_data_i;
  logic [N-1:0]    s_valid_i;
  logic [N-1:0]    s_ready_o;
  logic [DW-1:0]   m_data_o;
  logic            m_valid_o;
  logic            m_ready_i;
  logic [IW-1:0]   m_id_o;
  logic            m_last_o;
  arb_state_e      dbg_state;

  modport slave (
    input  s_data_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_valid_o, m_id_o, m_last_o, dbg_state
  );

  modport master (
    output s_data_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_valid_o, m_id_o, m_last_o, dbg_state
  );

endinterface

// File: rtl/stream_rr_pick.sv
// Combinational round-robin first-set finder: returns the first set bit of req
// scanning ptr, ptr+1, ... modulo N.
module stream_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Scan from the farthest offset down so the nearest set bit wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      j = (int'(ptr) + off) % N;
      if (req[j]) begin
        idx = IW'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_upsizer_arbiter.sv
// Round-robin arbiter feeding one width upsizer: a grant is held for exactly
// SCALE accepted beats so every assembled wide word has a single source.
module stream_upsizer_arbiter
  import stream_upsizer_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int SCALE = 4
) (
  input logic                     clk,
  input logic                     rst,
  stream_upsizer_arbiter_if.slave bus
);

  localparam int            IW        = clog2_min1(N);
  localparam int            CW        = clog2_min1(SCALE);
  localparam logic [CW-1:0] LAST_BEAT = CW'(SCALE - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [DW-1:0] sel_data;
  logic          sel_valid;
  logic [N-1:0]  s_ready;
  logic          m_valid;
  logic          m_last;
  logic          beat;

  stream_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (bus.s_valid_i),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q == IW'(k)) begin
        sel_data  = bus.s_data_i[k*DW +: DW];
        sel_valid = bus.s_valid_i[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    s_ready = '0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    beat    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The grant cycle moves no data; the burst starts on the next cycle.
        if (pick_any) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        m_valid = sel_valid;
        m_last  = sel_valid & (cnt_q == LAST_BEAT);
        for (int k = 0; k < N; k++) begin
          s_ready[k] = (gnt_q == IW'(k)) & bus.m_ready_i;
        end
        beat = sel_valid & bus.m_ready_i;
        if (beat) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = IDLE;
            ptr_d   = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + IW'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset silences the handshake immediately, even while still LOCKED.
    if (rst) begin
      s_ready = '0;
      m_valid = 1'b0;
      m_last  = 1'b0;
    end
  end

  assign bus.s_ready_o = s_ready;
  assign bus.m_valid_o = m_valid;
  assign bus.m_last_o  = m_last;
  assign bus.m_data_o  = m_valid ? sel_data : '0;
  assign bus.m_id_o    = gnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_stream_upsizer_arbiter.sv
// Directed bench for stream_upsizer_arbiter (N=3, DW=8, SCALE=4): a burst-level
// model checks outputs every cycle and a beat queue holds hand-computed beats.
module tb_stream_upsizer_arbiter;
  import stream_upsizer_arbiter_pkg::*;

  localparam int N     = 3;
  localparam int DW    = 8;
  localparam int SCALE = 4;
  localparam int IW    = 2;
  localparam int W     = 1 + IW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_upsizer_arbiter_if #(.N(N), .DW(DW), .IW(IW)) bus ();

  stream_upsizer_arbiter #(.N(N), .DW(DW), .SCALE(SCALE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // producer side: beats still to offer, beats already accepted
  int budget[N];
  int prod_cnt[N];
  logic rdy_toggle;

  // burst-level model: current owner (-1 none), beats accepted, rotation start
  int owner = -1;
  int beats = 0;
  int rr = 0;
  int last_id = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_inputs();
    for (int k = 0; k < N; k++) begin
      bus.s_valid_i[k] = (budget[k] > 0);
      bus.s_data_i[k*DW +: DW] = DW'(k * 16 + (prod_cnt[k] % 15) + 1);
    end
  endtask

  task automatic push_burst(input int id, input int first);
    for (int i = 0; i < SCALE; i++)
      exp_q.push_back({(i == SCALE - 1), IW'(id), DW'(first + i)});
  endtask

  // Compare on the falling edge, then update the model with the inputs that
  // the next rising edge will see.
  task automatic sample_cycle();
    logic [N-1:0] exp_rdy;
    logic         exp_valid;
    logic         exp_last;
    logic [W-1:0] obs;
    logic [W-1:0] want;
    int           order[$];
    exp_rdy   = '0;
    exp_valid = 1'b0;
    exp_last  = 1'b0;
    if (!rst && owner >= 0) begin
      exp_valid = bus.s_valid_i[owner];
      exp_rdy[owner] = bus.m_ready_i;
      exp_last = exp_valid && (beats == SCALE - 1);
    end
    check("m_valid", 32'(bus.m_valid_o), 32'(exp_valid));
    check("s_ready", 32'(bus.s_ready_o), 32'(exp_rdy));
    check("m_last", 32'(bus.m_last_o), 32'(exp_last));
    check("m_id", 32'(bus.m_id_o), 32'(last_id));
    check("state", 32'(bus.dbg_state), 32'(owner >= 0));
    if (exp_valid) check("m_data", 32'(bus.m_data_o), 32'(bus.s_data_i[owner*DW +: DW]));

    if (bus.m_valid_o && bus.m_ready_i) begin
      obs = {bus.m_last_o, bus.m_id_o, bus.m_data_o};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_extra: got %0h expected none at %0t", obs, $time);
      end else begin
        want = exp_q.pop_front();
        check("beat", 32'(obs), 32'(want));
      end
    end
    for (int k = 0; k < N; k++) begin
      if (bus.s_valid_i[k] && bus.s_ready_o[k]) begin
        prod_cnt[k]++;
        budget[k]--;
      end
    end

    if (rst) begin
      owner = -1; beats = 0; rr = 0; last_id = 0;
    end else if (owner < 0) begin
      for (int i = 0; i < N; i++) order.push_back((rr + i) % N);
      foreach (order[j]) begin
        if (owner < 0 && bus.s_valid_i[order[j]]) begin
          owner = order[j];
          last_id = owner;
          beats = 0;
        end
      end
    end else if (bus.s_valid_i[owner] && bus.m_ready_i) begin
      beats++;
      if (beats == SCALE) begin
        rr = (owner + 1) % N;
        owner = -1;
        beats = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample_cycle();
    @(posedge clk);
    #1;
    bus.m_ready_i = rdy_toggle ? ~bus.m_ready_i : 1'b1;
    apply_inputs();
  endtask

  task automatic wait_drain(input string name, input int max, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_size(input string name, input int target, input int max);
    int n = 0;
    while (exp_q.size() > target && n < max) begin
      step();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'(target));
  endtask

  task automatic reset_env();
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin budget[k] = 0; prod_cnt[k] = 0; end
    exp_q.delete();
    apply_inputs();
    step();
    step();
    rst = 1'b0;
    apply_inputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    rdy_toggle = 1'b0;
    bus.m_ready_i = 1'b1;
    for (int k = 0; k < N; k++) begin budget[k] = 0; prod_cnt[k] = 0; end
    apply_inputs();
    reset_env();
    check("rst_m_valid", 32'(bus.m_valid_o), 0);
    check("rst_s_ready", 32'(bus.s_ready_o), 0);
    check("rst_m_id", 32'(bus.m_id_o), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));

    // single requester 1
    budget[1] = 4; apply_inputs();
    push_burst(1, 'h11);
    #1 check("t1_arb_cycle_valid", 32'(bus.m_valid_o), 0);
    step();
    check("t1_first_valid", 32'(bus.m_valid_o), 1);
    check("t1_first_id", 32'(bus.m_id_o), 1);
    check("t1_first_data", 32'(bus.m_data_o), 'h11);
    wait_drain("t1_drain", 40, n);
    check("t1_cycles", n, 4);
    check("t1_idle_after", 32'(bus.dbg_state), 32'(IDLE));
    check("t1_idle_valid", 32'(bus.m_valid_o), 0);

    // fair contention, all three requesting
    reset_env();
    for (int k = 0; k < N; k++) budget[k] = 8;
    apply_inputs();
    push_burst(0, 'h01); push_burst(1, 'h11); push_burst(2, 'h21);
    push_burst(0, 'h05); push_burst(1, 'h15); push_burst(2, 'h25);
    wait_drain("t2_drain", 80, n);
    check("t2_cycles", n, 30);

    // backpressure: ready toggles every cycle
    reset_env();
    rdy_toggle = 1'b1;
    budget[0] = 4; apply_inputs();
    push_burst(0, 'h01);
    wait_drain("t3_drain", 40, n);
    check("t3_cycles", n, 9);
    rdy_toggle = 1'b0;
    bus.m_ready_i = 1'b1;

    // granted requester pauses mid-burst, requester 1 stays blocked
    reset_env();
    budget[0] = 2; budget[1] = 4; apply_inputs();
    push_burst(0, 'h01); push_burst(1, 'h11);
    wait_size("t4_two_beats", 6, 40);
    for (int i = 0; i < 5; i++) begin
      check("t4_blocked_rdy1", 32'(bus.s_ready_o[1]), 0);
      check("t4_hold_id", 32'(bus.m_id_o), 0);
      check("t4_hold_state", 32'(bus.dbg_state), 32'(LOCKED));
      step();
    end
    budget[0] = 2; apply_inputs();
    wait_drain("t4_drain", 40, n);

    // reset after beat 2 of a burst
    reset_env();
    budget[0] = 6; budget[1] = 4; apply_inputs();
    exp_q.push_back({1'b0, IW'(0), DW'('h01)});
    exp_q.push_back({1'b0, IW'(0), DW'('h02)});
    wait_drain("t5_two_beats", 40, n);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 32'(bus.m_valid_o), 0);
    check("t5_rst_ready", 32'(bus.s_ready_o), 0);
    step();
    check("t5_after_state", 32'(bus.dbg_state), 32'(IDLE));
    check("t5_after_valid", 32'(bus.m_valid_o), 0);
    check("t5_after_ready", 32'(bus.s_ready_o), 0);
    rst = 1'b0;
    push_burst(0, 'h03); push_burst(1, 'h11);
    wait_drain("t5_drain", 40, n);

    // non-power-of-two wrap: burst by 1 leaves priority on 2
    reset_env();
    budget[1] = 4; apply_inputs();
    push_burst(1, 'h11);
    wait_drain("t6_first", 40, n);
    budget[2] = 8; budget[0] = 4; apply_inputs();
    push_burst(2, 'h21); push_burst(0, 'h01); push_burst(2, 'h25);
    wait_drain("t6_drain", 60, n);
    check("t6_cycles", n, 15);

    step();
    check("end_queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
